booth_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one booth multiplier core (start/X/Y in, valid/Z out) between N_REQ requesters. It captures the winning requester's signed operands and issues a one-cycle start pulse to the core. It then waits for the core's valid rising edge and returns the product to the owner with a one-cycle done pulse. A watchdog aborts the operation with an error flag if the core never responds.

---
 rtl/booth_share_arbiter_pkg.sv | 33 +++
 rtl/booth_share_arbiter_if.sv | 39 +++
 rtl/booth_rr_pick.sv | 38 +++
 rtl/booth_share_arbiter.sv | 136 +++++++++++++
 tb/tb_booth_share_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_arb_pkg
// Brief    : Shared types, default sizes and helper functions for the booth
//            multiplier sharing arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package booth_arb_pkg;

  localparam int c_DEF_N_REQ   = 4;
  localparam int c_DEF_WIDTH   = 4;
  localparam int c_DEF_TIMEOUT = 31;

  // Sequencer states; two bits cover all four.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Timer must be able to hold the value TIMEOUT itself.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Width of a requester index (at least one bit).
  function automatic int idx_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_share_arbiter_if
// Brief    : Requester-side and multiplier-core-side signal bundle of the
//            booth sharing arbiter. The arbiter uses the slave modport; the
//            environment (requesters + core) uses the master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface booth_share_arbiter_if
  import booth_arb_pkg::*;
#(
  parameter int N_REQ = c_DEF_N_REQ,
  parameter int WIDTH = c_DEF_WIDTH
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_x;
  logic [N_REQ*WIDTH-1:0] req_y;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [2*WIDTH-1:0]     result;
  logic                   err;
  logic                   busy;
  logic                   mul_start;
  logic [WIDTH-1:0]       mul_x;
  logic [WIDTH-1:0]       mul_y;
  logic                   mul_valid;
  logic [2*WIDTH-1:0]     mul_z;

  modport slave (
    input  req, req_x, req_y, mul_valid, mul_z,
    output gnt, done, result, err, busy, mul_start, mul_x, mul_y
  );

  modport master (
    output req, req_x, req_y, mul_valid, mul_z,
    input  gnt, done, result, err, busy, mul_start, mul_x, mul_y
  );
endinterface
`default_nettype wire

// File: rtl/booth_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : booth_rr_pick
// Brief    : Combinational rotate-priority picker. Returns the first set
//            request bit at or above i_ptr, wrapping around to bit 0.
// Revision : 1.0 - initial release
// ============================================================================
module booth_rr_pick
  import booth_arb_pkg::*;
#(
  parameter int N_REQ = c_DEF_N_REQ,
  parameter int PW    = idx_width(N_REQ)
) (
  input  wire logic [N_REQ-1:0] i_req,
  input  wire logic [PW-1:0]    i_ptr,
  output logic                  o_found,
  output logic [PW-1:0]         o_idx
);

  int w_pos;

  // Scan offsets from farthest to nearest so the nearest hit to i_ptr wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      if (i_req[PW'(w_pos)]) begin
        o_found = 1'b1;
        o_idx   = PW'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/booth_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : booth_share_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one booth multiplier core
//            between N_REQ requesters, with a response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module booth_share_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N_REQ   = c_DEF_N_REQ,
  parameter int WIDTH   = c_DEF_WIDTH,
  parameter int TIMEOUT = c_DEF_TIMEOUT
) (
  input  wire logic              clk,
  input  wire logic              rst,
  booth_share_arbiter_if.slave   bus
);

  localparam int              PW       = idx_width(N_REQ);
  localparam int              TW       = timer_width(TIMEOUT);
  localparam logic [N_REQ-1:0] c_ONE   = N_REQ'(1);
  localparam logic [TW-1:0]   c_TMO    = TW'(TIMEOUT);
  localparam logic [PW-1:0]   c_LAST   = PW'(N_REQ - 1);

  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_owner;
  logic [TW-1:0]      r_timer;
  logic               r_valid_q;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_done;
  logic [2*WIDTH-1:0] r_result;
  logic               r_err;
  logic               r_mul_start;
  logic [WIDTH-1:0]   r_mul_x;
  logic [WIDTH-1:0]   r_mul_y;

  logic               w_rise;
  logic [N_REQ-1:0]   w_req_avail;
  logic               w_found;
  logic [PW-1:0]      w_idx;
  logic [WIDTH-1:0]   w_x [N_REQ];
  logic [WIDTH-1:0]   w_y [N_REQ];

  // Only a fresh rising edge of the core's level flag marks completion.
  assign w_rise = bus.mul_valid & ~r_valid_q;

  // The owner whose done is firing this cycle may not be re-granted yet.
  assign w_req_avail = bus.req & ~r_done;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign w_x[gi] = bus.req_x[gi*WIDTH +: WIDTH];
    assign w_y[gi] = bus.req_y[gi*WIDTH +: WIDTH];
  end

  booth_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .i_req   (w_req_avail),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Sequencer: grant, issue start, wait for core or watchdog, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_timer     <= '0;
      r_valid_q   <= 1'b0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_x     <= '0;
      r_mul_y     <= '0;
    end else begin
      r_valid_q   <= bus.mul_valid;
      r_gnt       <= '0;
      r_done      <= '0;
      r_mul_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner <= w_idx;
            r_mul_x <= w_x[w_idx];
            r_mul_y <= w_y[w_idx];
            r_gnt   <= c_ONE << w_idx;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mul_start <= 1'b1;
          r_timer     <= '0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A core response takes priority over a coinciding timeout.
          if (w_rise) begin
            r_result <= bus.mul_z;
            r_err    <= 1'b0;
            r_state  <= ST_RESP;
          end else if (r_timer == c_TMO) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_state  <= ST_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP: begin
          r_done  <= c_ONE << r_owner;
          r_ptr   <= (r_owner == c_LAST) ? '0 : r_owner + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.mul_start = r_mul_start;
  assign bus.mul_x     = r_mul_x;
  assign bus.mul_y     = r_mul_y;

endmodule
`default_nettype wire

// File: tb/tb_booth_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_share_arbiter
// Brief    : Directed self-checking bench for booth_share_arbiter with a
//            behavioural multiplier core driven from the stimulus tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_share_arbiter;
  import booth_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Shared observation variables (tests run strictly one after another).
  logic [N-1:0]   g, d, da;
  logic [W-1:0]   ox, oy, oxe;
  logic           bg, bd, e;
  int             st, cy;
  logic [2*W-1:0] r;

  booth_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  booth_share_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .TIMEOUT (31)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.req_x[i*W +: W] = x;
    bus.req_y[i*W +: W] = y;
  endtask

  // Runs one operation from grant to done, acting as the multiplier core.
  // mode 0: valid rises lat cycles after start; 1: never; 2: stale valid.
  task automatic run_op(input int mode, input int lat, input logic [N-1:0] clr,
                        output logic [N-1:0] o_gnt, output logic [W-1:0] o_x,
                        output logic [W-1:0] o_y, output logic o_busy_g,
                        output int o_starts, output int o_cyc,
                        output logic [N-1:0] o_done, output logic [2*W-1:0] o_res,
                        output logic o_err, output logic [W-1:0] o_x_end,
                        output logic o_busy_d, output logic [N-1:0] o_done_after);
    int n;
    logic signed [2*W-1:0] sx, sy;
    logic [2*W-1:0] prod;
    o_gnt = '0; o_x = '0; o_y = '0; o_busy_g = 1'b0; o_starts = 0; o_cyc = -1;
    o_done = '0; o_res = '0; o_err = 1'b0; o_x_end = '0; o_busy_d = 1'b1;
    o_done_after = '1;
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    if (bus.gnt == '0) begin
      checks++; errors++;
      $display("FAIL grant_wait: no grant within %0d cycles", n);
      return;
    end
    o_gnt = bus.gnt; o_x = bus.mul_x; o_y = bus.mul_y; o_busy_g = bus.busy;
    if (bus.mul_start) o_starts++;
    if (mode == 2) begin
      bus.mul_valid = 1'b1;
      bus.mul_z     = 8'h55;
    end
    tick();
    sx   = {{W{bus.mul_x[W-1]}}, bus.mul_x};
    sy   = {{W{bus.mul_y[W-1]}}, bus.mul_y};
    prod = sx * sy;
    for (int c = 0; c < 60; c++) begin
      if (bus.mul_start) o_starts++;
      if (bus.done != '0) begin
        o_cyc = c; o_done = bus.done; o_res = bus.result; o_err = bus.err;
        o_x_end = bus.mul_x; o_busy_d = bus.busy;
        break;
      end
      if (mode == 0 && c == lat) begin
        bus.mul_valid = 1'b1; bus.mul_z = prod;
      end
      if (mode == 2 && c == 2) bus.mul_valid = 1'b0;
      if (mode == 2 && c == 5) begin
        bus.mul_valid = 1'b1; bus.mul_z = prod;
      end
      tick();
    end
    if (o_done == '0) begin
      checks++; errors++;
      $display("FAIL done_wait: no done within 60 cycles of start");
    end
    bus.req       = bus.req & ~clr;
    bus.mul_valid = 1'b0;
    tick();
    o_done_after = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.gnt !== '0)       begin errors++; $display("FAIL rst_gnt: got %h exp 0", bus.gnt); end
    checks++; if (bus.done !== '0)      begin errors++; $display("FAIL rst_done: got %h exp 0", bus.done); end
    checks++; if (bus.result !== '0)    begin errors++; $display("FAIL rst_result: got %h exp 0", bus.result); end
    checks++; if (bus.err !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b exp 0", bus.err); end
    checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
    checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b exp 0", bus.mul_start); end
    checks++; if ({bus.mul_x, bus.mul_y} !== '0) begin errors++; $display("FAIL rst_operands: got %h exp 0", {bus.mul_x, bus.mul_y}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_ops(0, 4'd5, 4'd7);
    bus.req = 4'b0001;
    run_op(0, 4, 4'b0001, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (g !== 4'b0001)  begin errors++; $display("FAIL single_gnt: got %b exp 0001", g); end
    checks++; if (ox !== 4'd5)    begin errors++; $display("FAIL single_x: got %h exp 5", ox); end
    checks++; if (oy !== 4'd7)    begin errors++; $display("FAIL single_y: got %h exp 7", oy); end
    checks++; if (bg !== 1'b1)    begin errors++; $display("FAIL single_busy: got %b exp 1", bg); end
    checks++; if (st != 1)        begin errors++; $display("FAIL single_starts: got %0d exp 1", st); end
    checks++; if (cy != 6)        begin errors++; $display("FAIL single_latency: got %0d exp 6", cy); end
    checks++; if (d !== 4'b0001)  begin errors++; $display("FAIL single_done: got %b exp 0001", d); end
    checks++; if (r !== 8'd35)    begin errors++; $display("FAIL single_result: got %h exp 23", r); end
    checks++; if (e !== 1'b0)     begin errors++; $display("FAIL single_err: got %b exp 0", e); end
    checks++; if (oxe !== 4'd5)   begin errors++; $display("FAIL single_x_hold: got %h exp 5", oxe); end
    checks++; if (bd !== 1'b0)    begin errors++; $display("FAIL single_idle: got busy %b exp 0", bd); end
    checks++; if (da !== '0)      begin errors++; $display("FAIL single_done_pulse: got %b exp 0000", da); end
  endtask

  task automatic test_signed();
    set_ops(1, 4'hC, 4'd6);
    bus.req = 4'b0010;
    run_op(0, 2, 4'b0010, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (d !== 4'b0010)  begin errors++; $display("FAIL signed1_done: got %b exp 0010", d); end
    checks++; if (r !== 8'hE8)    begin errors++; $display("FAIL signed1_result: got %h exp e8", r); end
    checks++; if (e !== 1'b0)     begin errors++; $display("FAIL signed1_err: got %b exp 0", e); end
    set_ops(1, 4'h8, 4'h8);
    bus.req = 4'b0010;
    run_op(0, 1, 4'b0010, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (g !== 4'b0010)  begin errors++; $display("FAIL signed2_gnt: got %b exp 0010", g); end
    checks++; if (r !== 8'h40)    begin errors++; $display("FAIL signed2_result: got %h exp 40", r); end
  endtask

  task automatic test_contention();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_ops(0, 4'd3, 4'hE);
    set_ops(2, 4'd7, 4'd7);
    bus.req = 4'b0101;
    run_op(0, 3, 4'b0001, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (g !== 4'b0001)  begin errors++; $display("FAIL cont_first_gnt: got %b exp 0001", g); end
    checks++; if (r !== 8'hFA)    begin errors++; $display("FAIL cont_first_result: got %h exp fa", r); end
    run_op(0, 3, 4'b0100, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (g !== 4'b0100)  begin errors++; $display("FAIL cont_second_gnt: got %b exp 0100", g); end
    checks++; if (r !== 8'h31)    begin errors++; $display("FAIL cont_second_result: got %h exp 31", r); end
    // Pointer now sits at 3: requester 3 must beat requester 1.
    set_ops(1, 4'd1, 4'd1);
    set_ops(3, 4'd2, 4'd3);
    bus.req = 4'b1010;
    run_op(0, 2, 4'b1010, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (g !== 4'b1000)  begin errors++; $display("FAIL cont_ptr_gnt: got %b exp 1000", g); end
    checks++; if (r !== 8'h06)    begin errors++; $display("FAIL cont_ptr_result: got %h exp 06", r); end
  endtask

  task automatic test_all_active();
    logic [N-1:0]   exp_g [5];
    logic [2*W-1:0] exp_r [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h02};
    for (int i = 0; i < N; i++) set_ops(i, W'(i + 1), 4'd2);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_op(0, 1, (k == 4) ? 4'b1111 : 4'b0000, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
      checks++; if (g !== exp_g[k]) begin errors++; $display("FAIL rr_gnt_%0d: got %b exp %b", k, g, exp_g[k]); end
      checks++; if (r !== exp_r[k]) begin errors++; $display("FAIL rr_result_%0d: got %h exp %h", k, r, exp_r[k]); end
    end
  endtask

  task automatic test_timeout();
    set_ops(2, 4'd3, 4'd3);
    bus.req = 4'b0100;
    run_op(1, 0, 4'b0100, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (d !== 4'b0100)  begin errors++; $display("FAIL tmo_done: got %b exp 0100", d); end
    checks++; if (cy != 33)       begin errors++; $display("FAIL tmo_latency: got %0d exp 33", cy); end
    checks++; if (e !== 1'b1)     begin errors++; $display("FAIL tmo_err: got %b exp 1", e); end
    checks++; if (r !== 8'h00)    begin errors++; $display("FAIL tmo_result: got %h exp 00", r); end
    checks++; if (st != 1)        begin errors++; $display("FAIL tmo_starts: got %0d exp 1", st); end
    set_ops(0, 4'd2, 4'hD);
    bus.req = 4'b0001;
    run_op(0, 4, 4'b0001, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (r !== 8'hFA)    begin errors++; $display("FAIL tmo_next_result: got %h exp fa", r); end
    checks++; if (e !== 1'b0)     begin errors++; $display("FAIL tmo_next_err: got %b exp 0", e); end
  endtask

  task automatic test_stale_valid();
    set_ops(0, 4'd6, 4'hD);
    bus.req = 4'b0001;
    run_op(2, 0, 4'b0001, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (r !== 8'hEE)    begin errors++; $display("FAIL stale_result: got %h exp ee", r); end
    checks++; if (cy != 7)        begin errors++; $display("FAIL stale_latency: got %0d exp 7", cy); end
    checks++; if (e !== 1'b0)     begin errors++; $display("FAIL stale_err: got %b exp 0", e); end
  endtask

  task automatic test_reset_midop();
    int  n;
    bit  seen;
    set_ops(3, 4'd5, 4'd5);
    bus.req = 4'b1000;
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL midop_gnt: got %b exp 1000", bus.gnt); end
    tick(); tick(); tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b exp 1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midop_rst_busy: got %b exp 0", bus.busy); end
    checks++; if ({bus.mul_x, bus.mul_y} !== '0) begin errors++; $display("FAIL midop_rst_operands: got %h exp 0", {bus.mul_x, bus.mul_y}); end
    bus.req = '0;
    tick();
    rst = 1'b0;
    bus.mul_valid = 1'b1;
    bus.mul_z     = 8'h19;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done != '0 || bus.busy || bus.result != '0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midop_late_valid: got activity %b exp 0", seen); end
    bus.mul_valid = 1'b0;
    tick();
    set_ops(1, 4'hF, 4'd7);
    bus.req = 4'b0010;
    run_op(0, 3, 4'b0010, g, ox, oy, bg, st, cy, d, r, e, oxe, bd, da);
    checks++; if (d !== 4'b0010)  begin errors++; $display("FAIL midop_fresh_done: got %b exp 0010", d); end
    checks++; if (r !== 8'hF9)    begin errors++; $display("FAIL midop_fresh_result: got %h exp f9", r); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.mul_valid = 1'b0;
    bus.mul_z     = '0;
    test_reset();
    test_single();
    test_signed();
    test_contention();
    test_all_active();
    test_timeout();
    test_stale_valid();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
